// File: rtl/sa_dcache_wb.sv
// Write-back, write-allocate, set-associative data cache for the access stage.
// Hits complete combinationally; misses run a WB/FILL sequence on a line-wide memory port.
module sa_dcache_wb #(
    parameter int ADDR_W   = 32,
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_req,
    input  logic                        i_we,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [31:0]                 i_wdata,
    output logic [31:0]                 o_rdata,
    output logic                        o_ready,
    output logic                        o_stall,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [8*(2**OFFSET_W)-1:0]  o_mem_wdata,
    input  logic                        i_mem_ack,
    input  logic [8*(2**OFFSET_W)-1:0]  i_mem_line
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS   = 2**INDEX_W;
    localparam int LINE_W = 8 * (2**OFFSET_W);
    localparam int WORD_W = OFFSET_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]        r_state;
    logic [WAY_W-1:0]  r_victim;
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [LINE_W-1:0] r_data  [WAYS][SETS];
    logic [WAY_W-1:0]  r_rr    [SETS];
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [WORD_W-1:0]  w_word;
    logic               w_hit_any;
    logic [WAY_W-1:0]   w_hit_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_victim_dirty;
    logic               w_idle;
    logic               w_hit;
    logic               w_miss;
    logic [LINE_W-1:0]  w_hit_line;
    logic [31:0]        w_hit_word;
    logic               w_unused;

    assign w_tag    = i_addr[ADDR_W-1 -: TAG_W];
    assign w_index  = i_addr[OFFSET_W +: INDEX_W];
    assign w_word   = i_addr[OFFSET_W-1:2];
    assign w_unused = ^i_addr[1:0];

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_index]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    assign w_victim_dirty = r_valid[w_victim][w_index] & r_dirty[w_victim][w_index];
    assign w_idle         = (r_state == S_IDLE);
    assign w_hit          = i_req & w_idle & w_hit_any;
    assign w_miss         = i_req & w_idle & ~w_hit_any;
    assign w_hit_line     = r_data[w_hit_way][w_index];
    assign w_hit_word     = w_hit_line[32*w_word +: 32];

    assign o_rdata     = (w_hit & ~i_we) ? w_hit_word : 32'd0;
    assign o_ready     = w_hit;
    assign o_stall     = ~w_idle | (i_req & ~w_hit_any);
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_victim    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_victim  <= w_victim;
                        r_mem_req <= 1'b1;
                        if (w_victim_dirty) begin
                            r_state     <= S_WB;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_index], w_index, {OFFSET_W{1'b0}}};
                            r_mem_wdata <= r_data[w_victim][w_index];
                        end else begin
                            r_state    <= S_FILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        end
                    end else if (w_hit && i_we) begin
                        r_dirty[w_hit_way][w_index] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (i_mem_ack) begin
                        r_dirty[r_victim][w_index] <= 1'b0;
                        r_state     <= S_FILL;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                        r_mem_wdata <= '0;
                    end
                end
                S_FILL: begin
                    if (i_mem_ack) begin
                        r_valid[r_victim][w_index] <= 1'b1;
                        r_dirty[r_victim][w_index] <= 1'b0;
                        if (WAYS > 1) begin
                            r_rr[w_index] <= r_rr[w_index] + 1'b1;
                        end
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_FILL) && i_mem_ack) begin
            r_data[r_victim][w_index] <= i_mem_line;
            r_tag[r_victim][w_index]  <= w_tag;
        end else if (!rst && w_hit && i_we) begin
            r_data[w_hit_way][w_index][32*w_word +: 32] <= i_wdata;
        end
    end
endmodule

// File: tb/tb_sa_dcache_wb.sv
// Directed bench for sa_dcache_wb: a 2-way instance and a direct-mapped instance share
// stimulus, with a line-level memory model and a load-data scoreboard.
module tb_sa_dcache_wb;
    localparam int LINE_W = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              iReq;
    logic              iWe;
    logic [31:0]       iAddr;
    logic [31:0]       iWdata;
    logic              iMemAck;
    logic [LINE_W-1:0] iMemLine;
    logic              useDm;

    logic              saReq, dmReq, saAck, dmAck;
    logic [31:0]       saRdata, dmRdata;
    logic              saReady, dmReady, saStall, dmStall;
    logic              saMemReq, dmMemReq, saMemWe, dmMemWe;
    logic [31:0]       saMemAddr, dmMemAddr;
    logic [LINE_W-1:0] saMemWdata, dmMemWdata;

    logic [31:0]       oRdata;
    logic              oReady, oStall, oMemReq, oMemWe;
    logic [31:0]       oMemAddr;
    logic [LINE_W-1:0] oMemWdata;

    assign saReq = iReq & ~useDm;
    assign dmReq = iReq & useDm;
    assign saAck = iMemAck & ~useDm;
    assign dmAck = iMemAck & useDm;

    assign oRdata    = useDm ? dmRdata    : saRdata;
    assign oReady    = useDm ? dmReady    : saReady;
    assign oStall    = useDm ? dmStall    : saStall;
    assign oMemReq   = useDm ? dmMemReq   : saMemReq;
    assign oMemWe    = useDm ? dmMemWe    : saMemWe;
    assign oMemAddr  = useDm ? dmMemAddr  : saMemAddr;
    assign oMemWdata = useDm ? dmMemWdata : saMemWdata;

    sa_dcache_wb u_sa (
        .clk(clk), .rst(rst), .i_req(saReq), .i_we(iWe), .i_addr(iAddr), .i_wdata(iWdata),
        .o_rdata(saRdata), .o_ready(saReady), .o_stall(saStall),
        .o_mem_req(saMemReq), .o_mem_we(saMemWe), .o_mem_addr(saMemAddr),
        .o_mem_wdata(saMemWdata), .i_mem_ack(saAck), .i_mem_line(iMemLine)
    );

    sa_dcache_wb #(.WAYS(1)) u_dm (
        .clk(clk), .rst(rst), .i_req(dmReq), .i_we(iWe), .i_addr(iAddr), .i_wdata(iWdata),
        .o_rdata(dmRdata), .o_ready(dmReady), .o_stall(dmStall),
        .o_mem_req(dmMemReq), .o_mem_we(dmMemWe), .o_mem_addr(dmMemAddr),
        .o_mem_wdata(dmMemWdata), .i_mem_ack(dmAck), .i_mem_line(iMemLine)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0]       expQ [$];
    logic [31:0]       refMem  [logic [31:0]];
    logic [LINE_W-1:0] backMem [logic [31:0]];

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return 32'h1111_1000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic logic [LINE_W-1:0] backLine(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (backMem.exists(la)) return backMem[la];
        for (int w = 0; w < 16; w++) l[32*w +: 32] = initWord(la + 32'(4*w));
        return l;
    endfunction

    // CPU-visible value of a word: latest store, else whatever backing memory holds.
    function automatic logic [31:0] refRead(input logic [31:0] a);
        logic [31:0]       wa;
        logic [LINE_W-1:0] l;
        wa = {a[31:2], 2'b00};
        if (refMem.exists(wa)) return refMem[wa];
        l = backLine({a[31:6], 6'b0});
        return l[32*wa[5:2] +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] refLine(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 16; w++) l[32*w +: 32] = refRead(la + 32'(4*w));
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        iReq   = req;
        iWe    = we;
        iAddr  = addr;
        iWdata = wdata;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        refMem.delete();
    endtask

    // One access from issue to completion, acting as memory with a fixed ack delay.
    task automatic doAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ackDelay, input int expFill, input int expWb,
                            input logic [31:0] expWbAddr, input int expStall);
        int   waitCnt, stallCnt, nFill, nWb;
        bit   done;
        logic expWeNow;
        logic [31:0] lineAddr;
        lineAddr = {addr[31:6], 6'b0};
        applyStimulus(1'b1, we, addr, wdata);
        if (!we) expQ.push_back(refRead(addr));
        else refMem[{addr[31:2], 2'b00}] = wdata;
        waitCnt = 0; stallCnt = 0; nFill = 0; nWb = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (oReady) begin
                checkOutput("ready_stall", oStall, 1'b0);
                if (!we) checkOutput("load_data", oRdata, expQ.pop_front());
                else checkOutput("store_rdata", oRdata, 32'd0);
                done = 1'b1;
            end else begin
                if (oStall) stallCnt++;
                if (oMemReq) begin
                    expWeNow = (expWb != 0) && (nWb == 0);
                    checkOutput("mem_we", oMemWe, expWeNow);
                    checkOutput("mem_addr", oMemAddr, expWeNow ? expWbAddr : lineAddr);
                    checkOutput("mem_stall", oStall, 1'b1);
                    if (waitCnt == ackDelay) begin
                        if (oMemWe) begin
                            nWb++;
                            checkOutput("wb_line", oMemWdata, refLine(expWbAddr));
                            backMem[oMemAddr] = oMemWdata;
                        end else begin
                            nFill++;
                            iMemLine = backLine(oMemAddr);
                        end
                        iMemAck = 1'b1;
                        waitCnt = 0;
                    end else begin
                        waitCnt++;
                    end
                end
            end
            @(posedge clk);
            #1 iMemAck = 1'b0;
        end
        checkOutput("access_done", done, 1'b1);
        checkOutput("fill_count", nFill, expFill);
        checkOutput("wb_count", nWb, expWb);
        if (expStall >= 0) checkOutput("stall_cycles", stallCnt, expStall);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        bit found;
        useDm    = 1'b0;
        iMemAck  = 1'b0;
        iMemLine = '0;
        doReset();

        @(negedge clk);
        checkOutput("rst_mem_req", oMemReq, 1'b0);
        checkOutput("rst_mem_we", oMemWe, 1'b0);
        checkOutput("rst_mem_addr", oMemAddr, 32'd0);
        checkOutput("rst_mem_wdata", oMemWdata, '0);
        checkOutput("rst_stall", oStall, 1'b0);
        checkOutput("rst_ready", oReady, 1'b0);
        checkOutput("rst_rdata", oRdata, 32'd0);
        @(posedge clk); #1;

        doAccess(1'b0, 32'h0000_1000, 32'd0, 3, 1, 0, 32'd0, 5);
        doAccess(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 32'd0, 0);
        doAccess(1'b0, 32'h0000_1004, 32'd0, 0, 0, 0, 32'd0, 0);
        doAccess(1'b0, 32'h0000_5000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_9000, 32'd0, 2, 1, 1, 32'h0000_1000, 7);
        doAccess(1'b0, 32'h0000_1000, 32'd0, 10, 1, 0, 32'd0, 12);
        doAccess(1'b0, 32'h0000_1004, 32'd0, 0, 0, 0, 32'd0, 0);

        // Stray acks while idle must not start or disturb anything.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            iMemLine = '1;
            iMemAck  = 1'b1;
            @(posedge clk);
            #1 iMemAck = 1'b0;
            @(negedge clk);
            checkOutput("spur_mem_req", oMemReq, 1'b0);
            checkOutput("spur_stall", oStall, 1'b0);
            @(posedge clk); #1;
        end
        doAccess(1'b0, 32'h0000_1000, 32'd0, 0, 0, 0, 32'd0, 0);

        // Reset lands on the same edge as a fill ack.
        applyStimulus(1'b1, 1'b0, 32'h0000_D000, 32'd0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (oMemReq && !oMemWe) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("fill_seen", found, 1'b1);
        iMemLine = '1;
        iMemAck  = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        iMemAck = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        refMem.delete();
        @(negedge clk);
        checkOutput("rst_fill_req", oMemReq, 1'b0);
        checkOutput("rst_fill_stall", oStall, 1'b0);
        checkOutput("rst_fill_ready", oReady, 1'b0);
        @(posedge clk); #1;
        doAccess(1'b0, 32'h0000_1000, 32'd0, 0, 1, 0, 32'd0, 2);
        doAccess(1'b0, 32'h0000_D000, 32'd0, 0, 1, 0, 32'd0, 2);

        // Direct-mapped instance: 0x1000 and 0x5000 share a set and evict each other.
        doReset();
        useDm = 1'b1;
        backMem.delete();
        refMem.delete();
        doAccess(1'b0, 32'h0000_1000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_5000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b1, 32'h0000_5008, 32'hCAFE_F00D, 1, 0, 0, 32'd0, 0);
        doAccess(1'b0, 32'h0000_1000, 32'd0, 1, 1, 1, 32'h0000_5000, 5);
        doAccess(1'b0, 32'h0000_5008, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_1000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_5000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_1000, 32'd0, 1, 1, 0, 32'd0, 3);
        doAccess(1'b0, 32'h0000_5000, 32'd0, 1, 1, 0, 32'd0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
